// File: rtl/trafik_pkg.sv
// Shared state encoding, lamp patterns and the seconds-timer helper for trafik_kavsak.
// ST_FLASH exists only when TRAFIK_FLASH_EN is defined.
package trafik_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_GREEN = 3'd2,
        ST_AMBER = 3'd3,
        ST_WALK  = 3'd4
`ifdef TRAFIK_FLASH_EN
        ,
        ST_FLASH = 3'd5
`endif
    } state_e;

    // Lamps are active-low {green, amber, red}.
    localparam logic [2:0] LAMP_RED   = 3'b110;
    localparam logic [2:0] LAMP_AMBER = 3'b101;
    localparam logic [2:0] LAMP_GREEN = 3'b011;
    localparam logic [2:0] LAMP_OFF   = 3'b111;

    function automatic logic expired(input logic [7:0] sec, input logic tick, input logic [7:0] dur);
        return tick && (sec == dur - 8'd1);
    endfunction

endpackage

// File: rtl/trafik_kavsak_tick.sv
// One-second prescaler: counts 0..CLK_HZ-1, pulses tick_o on the last count,
// and restarts from zero whenever clr_i is high.
module trafik_tick #(
    parameter int unsigned CLK_HZ = 27_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CW'(CLK_HZ - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || tick_o) cnt_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/trafik_kavsak.sv
// Round-robin junction controller with pedestrian phase; optional night flash
// mode is compiled in with `define TRAFIK_FLASH_EN.
module trafik_kavsak
    import trafik_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 27_000_000,
    parameter int unsigned N_APPROACH = 2,
    parameter int unsigned GREEN_S    = 5,
    parameter int unsigned AMBER_S    = 2,
    parameter int unsigned CLEAR_S    = 1,
    parameter int unsigned WALK_S     = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          btn,
    input  logic                          ped_req,
    input  logic                          night,
    output logic [3*N_APPROACH-1:0]       led,
    output logic                          walk,
    output logic [$clog2(N_APPROACH)-1:0] active_dir
);

    localparam int unsigned DIR_W  = $clog2(N_APPROACH);
    localparam int unsigned HOLD_W = $clog2(N_APPROACH + 1);

    state_e              state_q, state_d;
    logic [DIR_W-1:0]    dir_q, dir_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [7:0]          sec_q, sec_d;
    logic                ped_q, ped_d;
    logic                tick, clr;
`ifdef TRAFIK_FLASH_EN
    logic                flash_q, flash_d;
`else
    logic                unused_night;
    assign unused_night = night;
`endif

    trafik_tick #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (clr),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        hold_d  = hold_q;
        ped_d   = ped_q | ped_req;
        case (state_q)
            ST_IDLE:  state_d = ST_CLEAR;
            // A served walk blocks the next one until every approach has had green.
            ST_CLEAR: if (expired(sec_q, tick, 8'(CLEAR_S))) begin
                if (ped_q && hold_q == '0) begin
                    state_d = ST_WALK;
                    ped_d   = 1'b0;
                end else begin
                    state_d = ST_GREEN;
                end
            end
            ST_GREEN: if (expired(sec_q, tick, 8'(GREEN_S))) state_d = ST_AMBER;
            ST_AMBER: if (expired(sec_q, tick, 8'(AMBER_S))) begin
                state_d = ST_CLEAR;
                dir_d   = (dir_q == DIR_W'(N_APPROACH - 1)) ? '0 : dir_q + 1'b1;
                if (hold_q != '0) hold_d = hold_q - 1'b1;
            end
            ST_WALK:  if (expired(sec_q, tick, 8'(WALK_S))) begin
                state_d = ST_CLEAR;
                hold_d  = HOLD_W'(N_APPROACH);
            end
`ifdef TRAFIK_FLASH_EN
            ST_FLASH: begin
                state_d = ST_CLEAR;
                dir_d   = '0;
            end
`endif
            default:  state_d = ST_IDLE;
        endcase
`ifdef TRAFIK_FLASH_EN
        if (night) state_d = ST_FLASH;
        if (state_d == ST_FLASH) ped_d = 1'b0;
`endif
        if (!btn) begin
            state_d = ST_IDLE;
            dir_d   = '0;
            hold_d  = '0;
            ped_d   = 1'b0;
        end
        clr   = (state_d != state_q) || (state_q == ST_IDLE);
        sec_d = clr ? '0 : (tick ? sec_q + 8'd1 : sec_q);
`ifdef TRAFIK_FLASH_EN
        flash_d = (state_q == ST_FLASH && state_d == ST_FLASH) ? (flash_q ^ tick) : 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dir_q   <= '0;
            hold_q  <= '0;
            sec_q   <= '0;
            ped_q   <= 1'b0;
`ifdef TRAFIK_FLASH_EN
            flash_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            hold_q  <= hold_d;
            sec_q   <= sec_d;
            ped_q   <= ped_d;
`ifdef TRAFIK_FLASH_EN
            flash_q <= flash_d;
`endif
        end
    end

    always_comb begin
        led = {N_APPROACH{LAMP_RED}};
        for (int unsigned i = 0; i < N_APPROACH; i++) begin
            if (dir_q == DIR_W'(i)) begin
                if (state_q == ST_GREEN)      led[3*i +: 3] = LAMP_GREEN;
                else if (state_q == ST_AMBER) led[3*i +: 3] = LAMP_AMBER;
            end
`ifdef TRAFIK_FLASH_EN
            if (state_q == ST_FLASH) led[3*i +: 3] = flash_q ? LAMP_OFF : LAMP_AMBER;
`endif
        end
    end

    assign walk       = (state_q == ST_WALK);
    assign active_dir = dir_q;

endmodule

// File: tb/tb_trafik_kavsak.sv
// Directed bench for trafik_kavsak at CLK_HZ=4, three approaches; expected lamp
// sequences are written out as cycle-count segments.
`timescale 1ns/1ps
module tb_trafik_kavsak;

    localparam int N = 3;
    localparam logic [2:0] R = 3'b110;
    localparam logic [2:0] G = 3'b011;
    localparam logic [2:0] A = 3'b101;
    localparam logic [2:0] O = 3'b111;

    logic           clk = 1'b0;
    logic           rst_n, btn, ped_req, night;
    logic [3*N-1:0] led;
    logic           walk;
    logic [1:0]     active_dir;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         n;
        int         dir;
        int         slot;
        logic [2:0] p;
        logic       w;
        logic       ped;
        logic       b;
        logic       ngt;
    } seg_t;

    trafik_kavsak #(
        .CLK_HZ     (4),
        .N_APPROACH (3),
        .GREEN_S    (2),
        .AMBER_S    (1),
        .CLEAR_S    (1),
        .WALK_S     (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (btn),
        .ped_req    (ped_req),
        .night      (night),
        .led        (led),
        .walk       (walk),
        .active_dir (active_dir)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [3*N-1:0] lamp_vec(input int slot, input logic [2:0] p);
        logic [3*N-1:0] v;
        for (int i = 0; i < N; i++) v[3*i +: 3] = (slot == N || slot == i) ? p : R;
        return v;
    endfunction

    function automatic seg_t sg(input int n, input int dir, input logic [2:0] p,
                                input logic w = 1'b0, input logic ped = 1'b0,
                                input logic b = 1'b1, input logic ngt = 1'b0,
                                input int slot = -1);
        seg_t s;
        s.n = n; s.dir = dir; s.p = p; s.w = w;
        s.ped = ped; s.b = b; s.ngt = ngt;
        s.slot = (slot < 0) ? dir : slot;
        return s;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0; btn = 1'b0; ped_req = 1'b0; night = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; btn = 1'b1; ped_req = 1'b0; night = 1'b0;
        #1;
        checks++;
        if (led !== 9'b110110110 || walk !== 1'b0 || active_dir !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: led=%b walk=%b dir=%0d, expected led=110110110 walk=0 dir=0", led, walk, active_dir);
        end
        @(negedge clk);
        checks++;
        if (led !== 9'b110110110 || walk !== 1'b0 || active_dir !== 2'd0) begin
            failures++;
            $display("FAIL reset_hold: led=%b walk=%b dir=%0d, expected led=110110110 walk=0 dir=0", led, walk, active_dir);
        end
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (led !== 9'b110110110 || walk !== 1'b0 || active_dir !== 2'd0) begin
                failures++;
                $display("FAIL idle_btn_low c%0d: led=%b walk=%b dir=%0d, expected led=110110110 walk=0 dir=0", c, led, walk, active_dir);
            end
        end
    endtask

    task automatic test_cycle();
        seg_t q[$];
        logic [3*N-1:0] exp;
        apply_reset();
        btn = 1'b1;
        q = '{sg(4,0,R), sg(8,0,G), sg(4,0,A), sg(4,1,R), sg(8,1,G), sg(4,1,A),
              sg(4,2,R), sg(8,2,G), sg(4,2,A), sg(4,0,R), sg(8,0,G)};
        foreach (q[s]) for (int c = 0; c < q[s].n; c++) begin
            @(negedge clk);
            exp = lamp_vec(q[s].slot, q[s].p);
            checks++;
            if (led !== exp || walk !== q[s].w || active_dir !== 2'(q[s].dir)) begin
                failures++;
                $display("FAIL round_robin seg%0d.%0d: led=%b walk=%b dir=%0d, expected led=%b walk=%b dir=%0d",
                         s, c, led, walk, active_dir, exp, q[s].w, q[s].dir);
            end
            ped_req = q[s].ped; btn = q[s].b; night = q[s].ngt;
        end
    endtask

    task automatic test_ped();
        seg_t q[$];
        logic [3*N-1:0] exp;
        apply_reset();
        btn = 1'b1;
        q = '{sg(4,0,R), sg(8,0,G), sg(4,0,A), sg(4,1,R), sg(2,1,G), sg(1,1,G,0,1),
              sg(5,1,G), sg(4,1,A), sg(4,2,R), sg(8,2,R,1), sg(4,2,R), sg(8,2,G)};
        foreach (q[s]) for (int c = 0; c < q[s].n; c++) begin
            @(negedge clk);
            exp = lamp_vec(q[s].slot, q[s].p);
            checks++;
            if (led !== exp || walk !== q[s].w || active_dir !== 2'(q[s].dir)) begin
                failures++;
                $display("FAIL ped_walk seg%0d.%0d: led=%b walk=%b dir=%0d, expected led=%b walk=%b dir=%0d",
                         s, c, led, walk, active_dir, exp, q[s].w, q[s].dir);
            end
            ped_req = q[s].ped; btn = q[s].b; night = q[s].ngt;
        end
    endtask

    // A pedestrian request pending at the btn drop must be discarded.
    task automatic test_btn_abort();
        seg_t q[$];
        logic [3*N-1:0] exp;
        apply_reset();
        btn = 1'b1;
        q = '{sg(4,0,R), sg(8,0,G), sg(4,0,A), sg(4,1,R), sg(1,1,G,0,1), sg(1,1,G,0,0,0),
              sg(2,0,R,0,0,0), sg(1,0,R), sg(4,0,R), sg(8,0,G), sg(4,0,A), sg(4,1,R)};
        foreach (q[s]) for (int c = 0; c < q[s].n; c++) begin
            @(negedge clk);
            exp = lamp_vec(q[s].slot, q[s].p);
            checks++;
            if (led !== exp || walk !== q[s].w || active_dir !== 2'(q[s].dir)) begin
                failures++;
                $display("FAIL btn_abort seg%0d.%0d: led=%b walk=%b dir=%0d, expected led=%b walk=%b dir=%0d",
                         s, c, led, walk, active_dir, exp, q[s].w, q[s].dir);
            end
            ped_req = q[s].ped; btn = q[s].b; night = q[s].ngt;
        end
    endtask

    task automatic test_async_reset();
        seg_t q[$];
        logic [3*N-1:0] exp;
        apply_reset();
        btn = 1'b1;
        q = '{sg(4,0,R), sg(8,0,G), sg(4,0,A), sg(4,1,R), sg(8,1,G), sg(2,1,A)};
        foreach (q[s]) for (int c = 0; c < q[s].n; c++) begin
            @(negedge clk);
            exp = lamp_vec(q[s].slot, q[s].p);
            checks++;
            if (led !== exp || walk !== q[s].w || active_dir !== 2'(q[s].dir)) begin
                failures++;
                $display("FAIL async_pre seg%0d.%0d: led=%b walk=%b dir=%0d, expected led=%b walk=%b dir=%0d",
                         s, c, led, walk, active_dir, exp, q[s].w, q[s].dir);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (led !== 9'b110110110 || walk !== 1'b0 || active_dir !== 2'd0) begin
            failures++;
            $display("FAIL async_reset: led=%b walk=%b dir=%0d, expected led=110110110 walk=0 dir=0", led, walk, active_dir);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            exp = (c < 4) ? lamp_vec(0, R) : lamp_vec(0, G);
            checks++;
            if (led !== exp || active_dir !== 2'd0) begin
                failures++;
                $display("FAIL after_reset c%0d: led=%b dir=%0d, expected led=%b dir=0", c, led, active_dir, exp);
            end
        end
    endtask

    // Second WALK only after all three approaches have been served again.
    task automatic test_ped_held();
        seg_t q[$];
        logic [3*N-1:0] exp;
        apply_reset();
        btn = 1'b1; ped_req = 1'b1;
        q = '{sg(4,0,R,0,1), sg(8,0,R,1,1), sg(4,0,R,0,1), sg(8,0,G,0,1), sg(4,0,A,0,1),
              sg(4,1,R,0,1), sg(8,1,G,0,1), sg(4,1,A,0,1), sg(4,2,R,0,1), sg(8,2,G,0,1),
              sg(4,2,A,0,1), sg(4,0,R,0,1), sg(8,0,R,1,1), sg(4,0,R,0,1), sg(8,0,G,0,1)};
        foreach (q[s]) for (int c = 0; c < q[s].n; c++) begin
            @(negedge clk);
            exp = lamp_vec(q[s].slot, q[s].p);
            checks++;
            if (led !== exp || walk !== q[s].w || active_dir !== 2'(q[s].dir)) begin
                failures++;
                $display("FAIL ped_held seg%0d.%0d: led=%b walk=%b dir=%0d, expected led=%b walk=%b dir=%0d",
                         s, c, led, walk, active_dir, exp, q[s].w, q[s].dir);
            end
            ped_req = q[s].ped; btn = q[s].b; night = q[s].ngt;
        end
        ped_req = 1'b0;
    endtask

`ifdef TRAFIK_FLASH_EN
    task automatic test_flash();
        seg_t q[$];
        logic [3*N-1:0] exp;
        apply_reset();
        btn = 1'b1;
        q = '{sg(4,0,R), sg(2,0,G), sg(1,0,G,0,0,1,1),
              sg(4,0,A,0,0,1,1,N), sg(4,0,O,0,0,1,1,N), sg(3,0,A,0,0,1,1,N), sg(1,0,A,0,0,1,0,N),
              sg(4,0,R), sg(8,0,G)};
        foreach (q[s]) for (int c = 0; c < q[s].n; c++) begin
            @(negedge clk);
            exp = lamp_vec(q[s].slot, q[s].p);
            checks++;
            if (led !== exp || walk !== q[s].w || active_dir !== 2'(q[s].dir)) begin
                failures++;
                $display("FAIL night_flash seg%0d.%0d: led=%b walk=%b dir=%0d, expected led=%b walk=%b dir=%0d",
                         s, c, led, walk, active_dir, exp, q[s].w, q[s].dir);
            end
            ped_req = q[s].ped; btn = q[s].b; night = q[s].ngt;
        end
    endtask
`else
    task automatic test_night_ignored();
        seg_t q[$];
        logic [3*N-1:0] exp;
        apply_reset();
        btn = 1'b1;
        q = '{sg(4,0,R), sg(2,0,G), sg(1,0,G,0,0,1,1), sg(5,0,G,0,0,1,1),
              sg(4,0,A,0,0,1,1), sg(4,1,R), sg(8,1,G)};
        foreach (q[s]) for (int c = 0; c < q[s].n; c++) begin
            @(negedge clk);
            exp = lamp_vec(q[s].slot, q[s].p);
            checks++;
            if (led !== exp || walk !== q[s].w || active_dir !== 2'(q[s].dir)) begin
                failures++;
                $display("FAIL night_ignored seg%0d.%0d: led=%b walk=%b dir=%0d, expected led=%b walk=%b dir=%0d",
                         s, c, led, walk, active_dir, exp, q[s].w, q[s].dir);
            end
            ped_req = q[s].ped; btn = q[s].b; night = q[s].ngt;
        end
        night = 1'b0;
    endtask
`endif

    initial begin
        rst_n = 1'b0; btn = 1'b0; ped_req = 1'b0; night = 1'b0;
        test_reset();
        test_cycle();
        test_ped();
        test_btn_abort();
        test_async_reset();
        test_ped_held();
`ifdef TRAFIK_FLASH_EN
        test_flash();
`else
        test_night_ignored();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
